serial_shift_out: RTL and testbench

Parametrised parallel-to-serial driver for the board's daisy-chained shift-register peripherals (seven-segment and LED banks). It accepts a DATA_W-bit word on a start strobe and shifts it out on a divided serial clock with data, clear and latch/enable strobes. It sits between the display/LED formatting logic and the SEGCLK/SEGDT/SEGEN/SEGCLR and LEDCLK/LEDDT/LEDEN/LEDCLR pins. One instance drives each chain.

---
 rtl/serial_shift_out.sv | 175 +++++++++++++++++
 tb/tb_serial_shift_out.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_shift_out.sv
// serial_shift_out
//   Parallel-to-serial driver for daisy-chained shift-register peripherals
//   (seven-segment / LED banks). A DATA_W-bit word is captured on start and
//   shifted out on a divided serial clock, framed by an optional active-low
//   chain clear before the data and a latch/enable strobe after it.
//
// Parameters
//   DATA_W    bits per transfer (>= 1)
//   DIV       serial-clock half-period in clk_100mhz cycles (>= 1)
//   MSB_FIRST 1: bit DATA_W-1 goes out first, 0: bit 0 goes out first
//   CLR_FIRST 1: emit an s_clr low pulse of DIV cycles before the data
//
// Ports
//   clk_100mhz  in   sole clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   one-cycle transfer request, honoured only when idle
//   par_data    in   word captured on the accepting cycle
//   busy        out  transfer in progress
//   done        out  one-cycle pulse in the first idle cycle after a transfer
//   s_clk       out  serial clock, idles low
//   s_dat       out  serial data, changes only while s_clk is low
//   s_en        out  latch strobe, DIV cycles after the last bit
//   s_clr       out  active-low chain clear, idles high
//
// Optional build macro
//   SERIAL_SHIFT_OUT_AUTO_REFRESH_EN: keep a copy of the last transmitted word
//   and start a transfer automatically whenever par_data differs from it
//   while idle.
module serial_shift_out #(
  parameter int DATA_W    = 64,
  parameter int DIV       = 2,
  parameter int MSB_FIRST = 1,
  parameter int CLR_FIRST = 1
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] par_data,
  output logic              busy,
  output logic              done,
  output logic              s_clk,
  output logic              s_dat,
  output logic              s_en,
  output logic              s_clr
);

  localparam int DC_W = $clog2(DIV + 1);
  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [DC_W-1:0] DIV_LAST = DC_W'(DIV - 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH
  } state_t;

  state_t            state, state_nxt;
  logic [DC_W-1:0]   div_cnt, div_nxt;
  logic [BC_W-1:0]   bit_cnt, bit_nxt;
  logic [DATA_W-1:0] sr, sr_nxt;
  logic              load;
  logic              trigger;
  logic              div_end;

  function automatic logic cur_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

`ifdef SERIAL_SHIFT_OUT_AUTO_REFRESH_EN
  logic [DATA_W-1:0] shadow;

  always_ff @(posedge clk_100mhz) begin
    if (rst)
      shadow <= '0;
    else if (load)
      shadow <= par_data;
  end

  assign trigger = start | (par_data != shadow);
`else
  assign trigger = start;
`endif

  assign div_end = (div_cnt == DIV_LAST);

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    sr_nxt    = sr;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          load      = 1'b1;
          sr_nxt    = par_data;
          bit_nxt   = '0;
          div_nxt   = '0;
          state_nxt = (CLR_FIRST != 0) ? ST_CLR : ST_SHIFT_LO;
        end
      end
      ST_CLR: begin
        if (div_end) begin
          div_nxt   = '0;
          state_nxt = ST_SHIFT_LO;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      ST_SHIFT_LO: begin
        if (div_end) begin
          div_nxt   = '0;
          state_nxt = ST_SHIFT_HI;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (div_end) begin
          div_nxt   = '0;
          sr_nxt    = shift_one(sr);
          bit_nxt   = bit_cnt + 1'b1;
          state_nxt = (bit_cnt == BIT_LAST) ? ST_LATCH : ST_SHIFT_LO;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      ST_LATCH: begin
        if (div_end) begin
          div_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each phase's pin levels
  // appear on the same edge that enters the phase.
  always_ff @(posedge clk_100mhz) begin
    sr <= sr_nxt;
    if (rst) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_clk   <= 1'b0;
      s_dat   <= 1'b0;
      s_en    <= 1'b0;
      s_clr   <= 1'b1;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      busy    <= (state_nxt != ST_IDLE);
      done    <= (state == ST_LATCH) && (state_nxt == ST_IDLE);
      s_clk   <= (state_nxt == ST_SHIFT_HI);
      s_en    <= (state_nxt == ST_LATCH);
      s_clr   <= (state_nxt != ST_CLR);
      if (state_nxt == ST_SHIFT_LO)
        s_dat <= cur_bit(sr_nxt);
    end
  end

endmodule

// File: tb/tb_serial_shift_out.sv
// Testbench for serial_shift_out. Two 8-bit instances run side by side:
//   dut_a: DIV=2, MSB first, clear pulse first
//   dut_b: DIV=1, LSB first, no clear pulse
// Expected transfers are queued at stimulus time; a monitor reassembles the
// bits seen at each s_clk rise and compares on every done pulse.
module tb_serial_shift_out;

  typedef struct {
    logic [7:0] word;      // bits in arrival order, first bit in bit 7
    int         busy_len;
    int         clr_len;
    int         en_len;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] start_w;
  logic [7:0] par_a, par_b;
  logic [1:0] busy_w, done_w, s_clk_w, s_dat_w, s_en_w, s_clr_w;

  int   checks;
  int   errors;
  int   done_cnt[2];
  exp_t q0[$];
  exp_t q1[$];

  serial_shift_out #(.DATA_W(8), .DIV(2), .MSB_FIRST(1), .CLR_FIRST(1)) dut_a (
    .clk_100mhz(clk), .rst(rst), .start(start_w[0]), .par_data(par_a),
    .busy(busy_w[0]), .done(done_w[0]), .s_clk(s_clk_w[0]), .s_dat(s_dat_w[0]),
    .s_en(s_en_w[0]), .s_clr(s_clr_w[0])
  );

  serial_shift_out #(.DATA_W(8), .DIV(1), .MSB_FIRST(0), .CLR_FIRST(0)) dut_b (
    .clk_100mhz(clk), .rst(rst), .start(start_w[1]), .par_data(par_b),
    .busy(busy_w[1]), .done(done_w[1]), .s_clk(s_clk_w[1]), .s_dat(s_dat_w[1]),
    .s_en(s_en_w[1]), .s_clr(s_clr_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk($sformatf("%s_busy%0d", tag, i),  busy_w[i],  0);
    chk($sformatf("%s_done%0d", tag, i),  done_w[i],  0);
    chk($sformatf("%s_sclk%0d", tag, i),  s_clk_w[i], 0);
    chk($sformatf("%s_sdat%0d", tag, i),  s_dat_w[i], 0);
    chk($sformatf("%s_sen%0d", tag, i),   s_en_w[i],  0);
    chk($sformatf("%s_sclr%0d", tag, i),  s_clr_w[i], 1);
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_w[i] && n < budget);
    chk($sformatf("done_seen%0d", i), done_w[i], 1);
  endtask

  task automatic push(input int i, input logic [7:0] w, input int bl, input int cl, input int el);
    exp_t e;
    e.word = w; e.busy_len = bl; e.clr_len = cl; e.en_len = el;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: accumulates per-transfer observations and scores on done.
  initial begin
    logic [7:0] bits[2];
    int   nb[2], bc[2], cc[2], ec[2], ov[2], se[2];
    logic pc[2], pd[2];
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      bits[i] = 0; nb[i] = 0; bc[i] = 0; cc[i] = 0; ec[i] = 0;
      ov[i] = 0; se[i] = 0; pc[i] = 0; pd[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          bits[i] = 0; nb[i] = 0; bc[i] = 0; cc[i] = 0; ec[i] = 0;
          ov[i] = 0; se[i] = 0; pc[i] = 0; pd[i] = 0;
        end else begin
          if (busy_w[i])              bc[i]++;
          if (!s_clr_w[i])            cc[i]++;
          if (s_en_w[i])              ec[i]++;
          if (s_en_w[i] && s_clk_w[i]) ov[i] = 1;
          if (s_clk_w[i] && !pc[i]) begin
            bits[i] = {bits[i][6:0], s_dat_w[i]};
            nb[i]++;
            if (s_dat_w[i] !== pd[i]) se[i]++;
          end
          if (done_w[i]) begin
            done_cnt[i]++;
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done%0d: got done, expected none", i);
            end else begin
              if (i == 0) e = q0.pop_front();
              else        e = q1.pop_front();
              chk($sformatf("word%0d", i),     bits[i], e.word);
              chk($sformatf("nbits%0d", i),    nb[i],   8);
              chk($sformatf("busy_len%0d", i), bc[i],   e.busy_len);
              chk($sformatf("clr_len%0d", i),  cc[i],   e.clr_len);
              chk($sformatf("en_len%0d", i),   ec[i],   e.en_len);
              chk($sformatf("en_clk_ovl%0d", i), ov[i], 0);
              chk($sformatf("setup%0d", i),    se[i],   0);
            end
            bits[i] = 0; nb[i] = 0; bc[i] = 0; cc[i] = 0; ec[i] = 0;
            ov[i] = 0; se[i] = 0;
          end
          pc[i] = s_clk_w[i];
          pd[i] = s_dat_w[i];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   rises, n, dc;
    logic prev, en_seen, bsy_seen;
    checks = 0; errors = 0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    rst = 1'b1; start_w = 2'b00; par_a = 8'h00; par_b = 8'h00;

    repeat (3) @(negedge clk);
    chk_idle(0, "rst");
    chk_idle(1, "rst");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk_idle(0, "idle");
    chk_idle(1, "idle");

`ifdef SERIAL_SHIFT_OUT_AUTO_REFRESH_EN
    // 00 -> 81 with start low: one transfer, bits 1,0,0,0,0,0,0,1
    par_a = 8'h81;
    push(0, 8'b1000_0001, 36, 2, 2);
    wait_done(0, 100);
    bsy_seen = 0;
    repeat (50) begin
      @(negedge clk);
      bsy_seen |= busy_w[0] | busy_w[1];
    end
    chk("refresh_quiet", bsy_seen, 0);
    chk("refresh_done_cnt", done_cnt[0], 1);
`else
    // A5, MSB first: bits 1,0,1,0,0,1,0,1
    par_a = 8'hA5; start_w[0] = 1'b1;
    push(0, 8'b1010_0101, 36, 2, 2);
    @(negedge clk);
    start_w[0] = 1'b0;
    chk("busy_after_start", busy_w[0], 1);
    repeat (10) @(negedge clk);
    par_a = 8'hFF; start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    wait_done(0, 100);
    // start in the done cycle: 3C -> bits 0,0,1,1,1,1,0,0
    par_a = 8'h3C; start_w[0] = 1'b1;
    push(0, 8'b0011_1100, 36, 2, 2);
    @(negedge clk);
    start_w[0] = 1'b0;
    chk("b2b_busy", busy_w[0], 1);
    chk("done_one_cycle", done_w[0], 0);
    wait_done(0, 100);
    @(negedge clk);
    chk("done_cnt_a", done_cnt[0], 2);

    // 01, LSB first, DIV=1, no clear: bits 1,0,0,0,0,0,0,0
    par_b = 8'h01; start_w[1] = 1'b1;
    push(1, 8'b1000_0000, 17, 0, 1);
    @(negedge clk);
    start_w[1] = 1'b0;
    wait_done(1, 60);
    @(negedge clk);
    chk("done_cnt_b", done_cnt[1], 1);

    // Abort after the 4th s_clk rise of F0 (s_dat is 1 at that point)
    par_a = 8'hF0; start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    rises = 0; n = 0; prev = 0;
    while (rises < 4 && n < 200) begin
      @(negedge clk);
      if (s_clk_w[0] && !prev) rises++;
      prev = s_clk_w[0];
      n++;
    end
    chk("abort_rises", rises, 4);
    dc = done_cnt[0];
    rst = 1'b1;
    @(negedge clk);
    chk_idle(0, "abort");
    rst = 1'b0;
    en_seen = 0;
    repeat (20) begin
      @(negedge clk);
      en_seen |= s_en_w[0];
    end
    chk("abort_no_en", en_seen, 0);
    chk("abort_no_done", done_cnt[0], dc);
    // 5A after abort: bits 0,1,0,1,1,0,1,0
    par_a = 8'h5A; start_w[0] = 1'b1;
    push(0, 8'b0101_1010, 36, 2, 2);
    @(negedge clk);
    start_w[0] = 1'b0;
    wait_done(0, 100);
`endif

    repeat (5) @(negedge clk);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
